pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the fetch stage. It holds the PC register and computes PC + STEP. It also resolves the next-PC choice among exception, return, call/jump, branch and sequential increment, and keeps a small return-address stack (RAS) for call/return pairs. It feeds instruction-memory addressing and the IF/ID pipeline register.

## Interface
Parameters:
- WIDTH, 32, PC and target width in bits
- STEP, 4, sequential increment added to PC
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h0000_0180, PC value loaded on Exception
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2)

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- Stall  in  1  hold PC and RAS this cycle (ignored when Exception=1)
- BranchTaken  in  1  redirect to BranchTarget
- BranchTarget  in  WIDTH  branch destination
- Jump  in  1  redirect to JumpTarget, no push
- Call  in  1  redirect to JumpTarget and push PCAddResult
- JumpTarget  in  WIDTH  jump/call destination
- Return  in  1  pop RAS top into PC
- Exception  in  1  redirect to EXC_VECTOR
- PCResult  out  WIDTH  current PC (registered)
- PCAddResult  out  WIDTH  PCResult + STEP (combinational)
- RasEmpty  out  1  RAS count == 0
- RasFull  out  1  RAS count == RAS_DEPTH
- RasUnderflow  out  1  registered one-cycle pulse: Return issued on empty RAS

## Operation
- Next-PC priority, highest first: Exception → EXC_VECTOR; Stall → hold; Return → RAS top; Call or Jump → JumpTarget; BranchTaken → BranchTarget; else PCAddResult.
- Exception overrides Stall. The RAS is unchanged on Exception.
- Stall (without Exception) freezes PCResult, RAS contents, pointer and count.
- Call pushes PCAddResult of the current cycle. Call and Jump together behave as Call.
- Return with count > 0: PC ← top entry, pointer decrements, count decrements.
- Return with count == 0: PC ← PCAddResult, RAS unchanged, RasUnderflow = 1 next cycle.
- Return and Call together: Return wins, Call is ignored, and no push occurs.
- Push when full: the oldest entry is overwritten (circular pointer wraps modulo RAS_DEPTH) and count stays at RAS_DEPTH.
- Arithmetic is modulo 2^WIDTH: PCResult = all-ones minus STEP + 1 wraps to 0 on increment. No alignment checks; targets pass through unmodified.
- RasEmpty and RasFull are decoded from the registered count.

## Timing
- Reset asserted (low) forces, immediately and regardless of Clk:
  - PCResult = RESET_VECTOR
  - RAS count = 0, pointer = 0, all RAS entries = 0
  - RasEmpty = 1, RasFull = 0, RasUnderflow = 0
- Reset mid-operation discards any pending redirect or push. The first edge after deassertion performs a normal next-PC evaluation from RESET_VECTOR.
- All redirect inputs are sampled on the rising edge; the new PCResult is visible after that edge, so redirect latency is 1 cycle.
- PCAddResult follows PCResult combinationally, with zero-cycle latency.
- A push or pop is effective for a Return in the immediately following cycle (back-to-back Call→Return returns the just-pushed address).
- RasUnderflow is high for exactly one cycle after the offending edge. It is not asserted when Stall or Exception suppressed the Return.

## Test plan
- Reset and increment (defaults): Reset low → PCResult=0x0, RasEmpty=1; release, 3 idle edges → PCResult 0x4, 0x8, 0xC; PCAddResult = PCResult+4 each cycle.
- Wrap: load 0xFFFFFFFC via Jump, one idle edge → PCResult=0x00000000.
- Priority: at PC=0x100, assert Exception, Stall, Return, Call, BranchTaken together → PCResult=0x180 and RAS count unchanged. Next, Stall alone for 2 edges → PCResult held at 0x180.
- Call/Return nesting:
  - Stimulus: at PC=0x40, Call to 0x200; at 0x200, Call to 0x300; then Return, Return.
  - PCResult sequence: 0x200, 0x300, 0x204, 0x44.
  - RasEmpty=1 at the end.
- Overflow and underflow (RAS_DEPTH=4):
  - Stimulus: 5 Calls pushing 0x4, 0x104, 0x204, 0x304, 0x404 (Call targets 0x100, 0x200, 0x300, 0x400, 0x500); then 5 Returns.
  - PCResult after the Returns: 0x404, 0x304, 0x204, 0x104.
  - The 5th Return goes to PCAddResult with RasUnderflow pulsed once.
  - RasFull=1 after the 4th push.
- Async reset mid-call: assert Reset between edges with count=2 → outputs return to reset values without a clock edge. After release, Return → RasUnderflow=1 and PCResult=RESET_VECTOR+4.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-stage redirect controls and PC/RAS status between the front end and the PC sequencer.
// The sequencer attaches through the slave modport; the control side uses the master modport.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Stall;
    logic             BranchTaken;
    logic [WIDTH-1:0] BranchTarget;
    logic             Jump;
    logic             Call;
    logic [WIDTH-1:0] JumpTarget;
    logic             Return;
    logic             Exception;
    logic [WIDTH-1:0] PCResult;
    logic [WIDTH-1:0] PCAddResult;
    logic             RasEmpty;
    logic             RasFull;
    logic             RasUnderflow;

    modport master (
        output Stall, BranchTaken, BranchTarget, Jump, Call, JumpTarget, Return, Exception,
        input  PCResult, PCAddResult, RasEmpty, RasFull, RasUnderflow
    );

    modport slave (
        input  Stall, BranchTaken, BranchTarget, Jump, Call, JumpTarget, Return, Exception,
        output PCResult, PCAddResult, RasEmpty, RasFull, RasUnderflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter register with prioritised next-PC selection and a circular return-address stack.
// Priority: Exception > Stall > Return > Call/Jump > BranchTaken > sequential.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int               RAS_DEPTH    = 4
) (
    input logic                Clk,
    input logic                Reset,
    pc_sequencer_if.slave      bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_add;
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    count;
    logic             underflow;

    assign pc_add = pc + WIDTH'(STEP);

    // ptr addresses the next free slot; when full it lands on the oldest entry,
    // so a push while full overwrites that entry without extra bookkeeping.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc        <= RESET_VECTOR;
            ptr       <= '0;
            count     <= '0;
            underflow <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else begin
            underflow <= 1'b0;
            if (bus.Exception) begin
                pc <= EXC_VECTOR;
            end else if (!bus.Stall) begin
                if (bus.Return) begin
                    if (count != '0) begin
                        pc    <= ras[ptr - PW'(1)];
                        ptr   <= ptr - PW'(1);
                        count <= count - CW'(1);
                    end else begin
                        pc        <= pc_add;
                        underflow <= 1'b1;
                    end
                end else if (bus.Call) begin
                    pc       <= bus.JumpTarget;
                    ras[ptr] <= pc_add;
                    ptr      <= ptr + PW'(1);
                    if (count != COUNT_FULL) begin
                        count <= count + CW'(1);
                    end
                end else if (bus.Jump) begin
                    pc <= bus.JumpTarget;
                end else if (bus.BranchTaken) begin
                    pc <= bus.BranchTarget;
                end else begin
                    pc <= pc_add;
                end
            end
        end
    end

    assign bus.PCResult     = pc;
    assign bus.PCAddResult  = pc_add;
    assign bus.RasEmpty     = (count == '0);
    assign bus.RasFull      = (count == COUNT_FULL);
    assign bus.RasUnderflow = underflow;
endmodule
